// File: rtl/mdu_if.sv
// mdu_if -- bundle between the E/D pipeline stages and the multiply/divide
// sequencing controller.
//   md_op_E   : E-stage multiply/divide/move-to op code (pipeline -> mdu)
//   rs_E/rt_E : forwarded operands in E (pipeline -> mdu)
//   md_use_D  : D-stage instruction touches the mdu or HI/LO (pipeline -> mdu)
//   hi/lo     : architectural HI/LO (mdu -> pipeline)
//   busy      : operation in flight (mdu -> pipeline)
//   done      : one-cycle pulse the cycle after a commit (mdu -> pipeline)
//   stall_md  : F/D stall request (mdu -> pipeline)
interface mdu_if;
    logic [2:0]  md_op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_md;

    // Pipeline side.
    modport master (
        output md_op_E, rs_E, rt_E, md_use_D,
        input  hi, lo, busy, done, stall_md
    );

    // Controller side.
    modport slave (
        input  md_op_E, rs_E, rt_E, md_use_D,
        output hi, lo, busy, done, stall_md
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- sequencing controller for the multi-cycle multiply/divide unit
// and its HI/LO registers.
//   clk   : pipeline clock
//   reset : asynchronous, active-high reset
//   bus   : mdu_if.slave (E-stage op/operands and D-stage use in;
//           hi, lo, busy, done, stall_md out)
// A mult/multu/div/divu accepted in IDLE computes its result immediately into
// pending registers, then holds busy for MULT_LAT / DIV_LAT cycles before
// committing to HI/LO. mthi/mtlo write HI/LO directly and never go busy.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      hi_reg, lo_reg;
    logic [31:0]      pend_hi_reg, pend_lo_reg;
    logic             done_reg;

    logic             is_start;
    logic [31:0]      res_hi_next, res_lo_next;
    logic [63:0]      prod_s, prod_u;

    assign is_start = (bus.md_op_E >= OP_MULT) && (bus.md_op_E <= OP_DIVU);

    // Full 64-bit products; sign extension to 64 bits makes the signed one exact.
    assign prod_s = $signed({{32{bus.rs_E[31]}}, bus.rs_E}) *
                    $signed({{32{bus.rt_E[31]}}, bus.rt_E});
    assign prod_u = {32'd0, bus.rs_E} * {32'd0, bus.rt_E};

    always_comb begin
        res_hi_next = hi_reg;
        res_lo_next = lo_reg;
        unique case (bus.md_op_E)
            OP_MULT:  {res_hi_next, res_lo_next} = prod_s;
            OP_MULTU: {res_hi_next, res_lo_next} = prod_u;
            OP_DIV: begin
                // Divide by zero keeps HI/LO; the single overflow case
                // (most-negative / -1) is pinned explicitly.
                if (bus.rt_E == 32'd0) begin
                    res_hi_next = hi_reg;
                    res_lo_next = lo_reg;
                end else if (bus.rs_E == 32'h8000_0000 && bus.rt_E == 32'hFFFF_FFFF) begin
                    res_hi_next = 32'd0;
                    res_lo_next = 32'h8000_0000;
                end else begin
                    res_lo_next = $signed(bus.rs_E) / $signed(bus.rt_E);
                    res_hi_next = $signed(bus.rs_E) % $signed(bus.rt_E);
                end
            end
            OP_DIVU: begin
                if (bus.rt_E != 32'd0) begin
                    res_lo_next = bus.rs_E / bus.rt_E;
                    res_hi_next = bus.rs_E % bus.rt_E;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (is_start) begin
                        pend_hi_reg <= res_hi_next;
                        pend_lo_reg <= res_lo_next;
                        cnt_reg     <= (bus.md_op_E <= OP_MULTU) ? CNT_W'(MULT_LAT - 1)
                                                                 : CNT_W'(DIV_LAT - 1);
                        state_reg   <= RUN;
                    end else if (bus.md_op_E == OP_MTHI) begin
                        hi_reg <= bus.rs_E;
                    end else if (bus.md_op_E == OP_MTLO) begin
                        lo_reg <= bus.rs_E;
                    end
                end
                RUN: begin
                    // New ops in E are held off by stall_md, so none are looked at here.
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        hi_reg    <= pend_hi_reg;
                        lo_reg    <= pend_lo_reg;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = done_reg;
    // Start decode is included so a dependent instruction in D is held in the
    // very cycle the op is accepted, before busy rises.
    assign bus.stall_md = bus.md_use_D & (bus.busy | is_start);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pushed to a scoreboard at each
// start, popped and compared on every done pulse.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [63:0] sb[$];
    logic [31:0] mh = '0, ml = '0;   // model HI/LO after all queued ops

    mdu_if bus();

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic built from unsigned magnitudes.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb;
        logic [31:0] ua, ub, q, r;
        model = {mh, ml};
        case (op)
            3'd1: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                model = ea * eb;
            end
            3'd2: model = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 0) begin
                ua = a[31] ? -a : a;
                ub = b[31] ? -b : b;
                q  = ua / ub;
                if (a[31] ^ b[31]) q = -q;
                r  = a - q * b;
                model = {r, q};
            end
            3'd4: if (b != 0) model = {a % b, a / b};
            default: ;
        endcase
    endfunction

    // Scoreboard consumer plus guard against ops issued while busy.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("commit_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
                chk("commit_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
            end
        end
        if (!reset && bus.busy && bus.md_op_E != 3'd0 && bus.md_op_E != 3'd7)
            chk("op_while_busy", {61'd0, bus.md_op_E}, 64'd0);
    end

    // Issue a multi-cycle op at posedge+1, measure busy length and stall cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic use_d);
        int n, sc;
        logic [63:0] e;
        bus.md_op_E = op; bus.rs_E = a; bus.rt_E = b; bus.md_use_D = use_d;
        e = model(op, a, b);
        sb.push_back(e);
        {mh, ml} = e;
        #1;
        chk("stall_start", {63'd0, bus.stall_md}, {63'd0, use_d});
        sc = bus.stall_md ? 1 : 0;
        @(posedge clk); #1;
        bus.md_op_E = 3'd0;
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            if (bus.stall_md) sc++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 64'(n), 64'(lat));
        chk("stall_cycles", 64'(sc), use_d ? 64'(lat + 1) : 64'd0);
        chk("done_pulse", {63'd0, bus.done}, 64'd1);
        chk("stall_release", {63'd0, bus.stall_md}, 64'd0);
        $display("op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h busy=%0d", op, a, b, bus.hi, bus.lo, n);
    endtask

    task automatic idle_step;
        @(posedge clk); #1;
        chk("done_low", {63'd0, bus.done}, 64'd0);
        chk("idle_busy", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        bus.md_op_E = 3'd0; bus.rs_E = '0; bus.rt_E = '0; bus.md_use_D = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_stall", {63'd0, bus.stall_md}, 64'd0);
        bus.md_use_D = 1'b1; #1;
        chk("use_d_no_op", {63'd0, bus.stall_md}, 64'd0);
        @(posedge clk); #1;

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1);      // mult
        chk("mult_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, bus.lo}, 64'hFFFF_FFFE);
        idle_step();
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);      // multu
        chk("multu_hi", {32'd0, bus.hi}, 64'h1);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);     // div back-to-back
        chk("div_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd0, 10, 1'b1);             // divu by zero
        chk("div0_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
        chk("div0_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        chk("ovf_lo", {32'd0, bus.lo}, 64'h8000_0000);
        chk("ovf_hi", {32'd0, bus.hi}, 64'd0);
        run_op(3'd3, 32'd100, 32'hFFFF_FFF9, 10, 1'b0);   // 100 / -7
        run_op(3'd4, 32'hFFFF_FFF0, 32'd7, 10, 1'b0);
        idle_step();

        // mthi/mtlo on consecutive cycles; no stall, no busy.
        bus.md_use_D = 1'b1;
        bus.md_op_E = 3'd5; bus.rs_E = 32'h1234_5678; #1;
        chk("mthi_stall", {63'd0, bus.stall_md}, 64'd0);
        @(posedge clk); #1;
        chk("mthi_hi", {32'd0, bus.hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, bus.busy}, 64'd0);
        bus.md_op_E = 3'd6; bus.rs_E = 32'h9ABC_DEF0; #1;
        chk("mtlo_stall", {63'd0, bus.stall_md}, 64'd0);
        @(posedge clk); #1;
        chk("mtlo_lo", {32'd0, bus.lo}, 64'h9ABC_DEF0);
        chk("mtlo_busy", {63'd0, bus.busy}, 64'd0);
        bus.md_op_E = 3'd0;
        mh = 32'h1234_5678; ml = 32'h9ABC_DEF0;
        $display("mthi/mtlo -> hi=%08h lo=%08h", bus.hi, bus.lo);

        // Async reset in the middle of a divide.
        bus.md_op_E = 3'd3; bus.rs_E = 32'd50; bus.rt_E = 32'd3;
        @(posedge clk); #1;
        bus.md_op_E = 3'd0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        sb.delete();
        mh = '0; ml = '0;
        #1;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_hi", {32'd0, bus.hi}, 64'd0);
        chk("midrst_lo", {32'd0, bus.lo}, 64'd0);
        chk("midrst_stall", {63'd0, bus.stall_md}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        $display("reset mid-div -> hi=%08h lo=%08h busy=%0d", bus.hi, bus.lo, bus.busy);
        repeat (12) idle_step();
        run_op(3'd1, 32'd12345, 32'hFFFF_FF00, 5, 1'b1);
        idle_step();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
